muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. It runs shift-add multiply or restoring divide
// on operand magnitudes, one bit per cycle, and applies the result sign at the end.
module muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ITER   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [4:0]        i_rd_addr,
  output logic              o_busy,
  output logic              o_rd_wren,
  output logic [4:0]        o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_funct3;
  logic [4:0]          r_rd_idx;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_op;
  logic [DATA_W-1:0]   r_dividend;
  logic                r_neg;
  logic                r_a_neg;
  logic                r_b_zero;
  logic                r_busy;
  logic                r_rd_wren;
  logic [4:0]          r_rd_addr;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W+1:0]   w_diff;
  logic                w_ge;
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [DATA_W-1:0]   w_result;

  assign o_busy    = r_busy;
  assign o_rd_wren = r_rd_wren;
  assign o_rd_addr = r_rd_addr;
  assign o_rd_data = r_rd_data;

  // Operand sign decode: MULH/DIV/REM signed both, MULHSU signed rs1 only
  assign w_a_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                      (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
  assign w_b_signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && i_rs1_data[DATA_W-1];
  assign w_b_neg    = w_b_signed && i_rs2_data[DATA_W-1];
  assign w_mag_a    = w_a_neg ? DATA_W'(0) - i_rs1_data : i_rs1_data;
  assign w_mag_b    = w_b_neg ? DATA_W'(0) - i_rs2_data : i_rs2_data;

  // One iteration of each algorithm; r_hi:r_lo is the shared accumulator
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
  assign w_shift = {r_hi, r_lo[DATA_W-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_op};
  assign w_ge    = !w_diff[DATA_W+1];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (2*DATA_W)'(0) - w_prod : w_prod;

  always_comb begin
    w_result = '0;
    if (!r_funct3[2]) begin
      w_result = (r_funct3 == 3'b000) ? w_prod_s[DATA_W-1:0] : w_prod_s[2*DATA_W-1:DATA_W];
    end else if (!r_funct3[1]) begin
      if (r_b_zero)   w_result = '1;
      else if (r_neg) w_result = DATA_W'(0) - r_lo;
      else            w_result = r_lo;
    end else begin
      if (r_b_zero)     w_result = r_dividend;
      else if (r_a_neg) w_result = DATA_W'(0) - r_hi;
      else              w_result = r_hi;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(ITER - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_funct3   <= '0;
      r_rd_idx   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_op       <= '0;
      r_dividend <= '0;
      r_neg      <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_wren  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_wren <= 1'b0;
      r_busy    <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_funct3   <= i_funct3;
            r_rd_idx   <= i_rd_addr;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_op       <= i_funct3[2] ? w_mag_b : w_mag_a;
            r_lo       <= i_funct3[2] ? w_mag_a : w_mag_b;
            r_neg      <= w_a_neg ^ w_b_neg;
            r_a_neg    <= w_a_neg;
            r_b_zero   <= (i_rs2_data == '0);
            r_dividend <= i_rs1_data;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_funct3[2]) begin
            r_hi <= w_ge ? DATA_W'(w_diff) : DATA_W'(w_shift);
            r_lo <= {r_lo[DATA_W-2:0], w_ge};
          end else begin
            r_hi <= w_sum[DATA_W:1];
            r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
          end
        end
        S_DONE: begin
          r_rd_data <= w_result;
          r_rd_addr <= r_rd_idx;
          r_rd_wren <= (r_rd_idx != 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit. Expected results come from native 64-bit arithmetic,
// are queued at start, and are checked against each write strobe.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy, wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  muldiv_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_funct3(funct3),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_rd_addr(rd),
    .o_busy(busy), .o_rd_wren(wren), .o_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    logic signed [31:0] a_s, b_s;
    sa = {{32{a[31]}}, a}; ua = {32'd0, a};
    sb = {{32{b[31]}}, b}; ub = {32'd0, b};
    a_s = a; b_s = b;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(a_s / b_s);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(a_s % b_s);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard consumer: every write strobe must match the oldest queued result
  always @(posedge clk) begin
    #1;
    if (wren) begin
      chk("wren_busy_low", 64'(busy), 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_wren", 64'd1, 64'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e[31:0]));
        chk("rd_addr", 64'(rd_addr), 64'(e[36:32]));
      end
    end
  end

  // Issue one op and follow it to completion; optionally re-pulse start while busy
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int poke_at);
    int n;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd = d;
    if (d != 5'd0) sb_q.push_back({d, model(f, a, b)});
    @(posedge clk); #1;
    chk("busy_rise", 64'(busy), 64'd1);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom); rd = 5'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke_at);
      if (!busy) break;
    end
    start = 1'b0;
    chk("latency", 64'(n), 64'd33);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4; rd = 5'd1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wren", 64'(wren), 64'd0);
      chk("rst_addr", 64'(rd_addr), 64'd0);
      chk("rst_data", 64'(rd_data), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Multiply sign variants
    run_op(3'b000, 32'hFFFF_FFFE, 32'h3, 5'd5, -1);
    run_op(3'b001, 32'hFFFF_FFFE, 32'h3, 5'd5, -1);
    run_op(3'b011, 32'hFFFF_FFFE, 32'h3, 5'd5, -1);
    run_op(3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd6, -1);
    // Divide / remainder signs
    run_op(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd7, -1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h2, 5'd8, -1);
    run_op(3'b101, 32'hFFFF_FFF9, 32'h2, 5'd9, -1);
    run_op(3'b111, 32'hFFFF_FFF9, 32'h2, 5'd10, -1);
    // Divide by zero and signed overflow
    run_op(3'b100, 32'd5, 32'd0, 5'd11, -1);
    run_op(3'b111, 32'd5, 32'd0, 5'd12, -1);
    run_op(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd12, -1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, -1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, -1);
    // Start while busy is ignored; x0 target never strobes
    run_op(3'b000, 32'd1234, 32'd5678, 5'd15, 10);
    run_op(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd0, -1);
    for (int i = 0; i < 8; i++)
      run_op(3'($urandom), $urandom, (i == 3) ? 32'd0 : $urandom, 5'($urandom_range(1, 31)), -1);

    // Reset mid-operation aborts without a strobe
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; rd = 5'd3;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wren", 64'(wren), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_abort_wren", 64'(wren), 64'd0);
    end

    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, -1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd21, -1);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
